lpc_frame_sched: RTL and testbench

LPC_FRAME_SCHED -- requirements
Module: lpc_frame_sched

---
 rtl/lpc_frame_sched.sv | 171 +++++++++++++++++
 tb/tb_lpc_frame_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_frame_sched.sv
// lpc_frame_sched
// ---------------------------------------------------------------------------
// Purpose: gathers FRAME_LEN input samples and streams each one to an LPC
// encoder. When a frame is complete, it tells the encoder to analyse it. It
// then waits up to TIMEOUT cycles for the encoder result. On a result it
// latches the coefficients and voicing decision and strobes a decoder load.
//
// Handshake: a sample is transferred on every rising edge where both s_valid
// and s_ready are high. s_valid may rise or fall freely. s_ready is high only
// while collecting a frame and does not depend on s_valid.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_ready  sample input stream (16-bit signed)
//   enc_x, enc_d_clk  registered sample and its one-cycle strobe to encoder
//   enc_v             one-cycle "frame complete, analyse" strobe to encoder
//   enc_vout, enc_voiced, enc_coef  encoder result (a0 in [15:0] .. a10 in [175:160])
//   dec_v             one-cycle load strobe to decoder
//   dec_voiced, dec_coef  latched result of the last delivered frame
//   dec_pulserate, dec_lpcrate  constant rates forwarded to decoder
//   frame_cnt         frames delivered to decoder (wraps at 16 bits)
//   err_timeout       sticky: encoder failed to answer within TIMEOUT cycles
//   dbg_enc_wait      debug view of the FSM (1 = ENC_WAIT, 0 = COLLECT)
// ---------------------------------------------------------------------------
module lpc_frame_sched #(
  parameter int FRAME_LEN  = 240,
  parameter int PULSE_RATE = 80,
  parameter int LPC_RATE   = 240,
  parameter int TIMEOUT    = 4095
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [15:0]  enc_x,
  output logic         enc_d_clk,
  output logic         enc_v,
  input  logic         enc_vout,
  input  logic         enc_voiced,
  input  logic [175:0] enc_coef,
  output logic         dec_v,
  output logic         dec_voiced,
  output logic [175:0] dec_coef,
  output logic [15:0]  dec_pulserate,
  output logic [15:0]  dec_lpcrate,
  output logic [15:0]  frame_cnt,
  output logic         err_timeout,
  output logic         dbg_enc_wait
);

  typedef enum logic {
    COLLECT  = 1'b0,
    ENC_WAIT = 1'b1
  } state_t;

  localparam logic [11:0] LAST_SAMPLE = 12'(FRAME_LEN - 1);
  localparam logic [15:0] LAST_WAIT   = 16'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [11:0]    smp_cnt_q, smp_cnt_d;
  logic [15:0]    wait_cnt_q, wait_cnt_d;
  // High for the first ENC_WAIT cycle, which issues enc_v.
  logic           first_q, first_d;
  logic [15:0]    enc_x_q, enc_x_d;
  logic           enc_d_clk_q, enc_d_clk_d;
  logic           enc_v_q, enc_v_d;
  logic           dec_v_q, dec_v_d;
  logic           dec_voiced_q, dec_voiced_d;
  logic [175:0]   dec_coef_q, dec_coef_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           err_q, err_d;

  always_comb begin
    state_d      = state_q;
    smp_cnt_d    = smp_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    first_d      = first_q;
    enc_x_d      = enc_x_q;
    enc_d_clk_d  = 1'b0;
    enc_v_d      = 1'b0;
    dec_v_d      = 1'b0;
    dec_voiced_d = dec_voiced_q;
    dec_coef_d   = dec_coef_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;

    case (state_q)
      COLLECT: begin
        // enc_vout is deliberately ignored here: no result is pending.
        if (s_valid) begin
          enc_x_d     = s_data;
          enc_d_clk_d = 1'b1;
          if (smp_cnt_q == LAST_SAMPLE) begin
            smp_cnt_d = '0;
            state_d   = ENC_WAIT;
            first_d   = 1'b1;
          end else begin
            smp_cnt_d = smp_cnt_q + 12'd1;
          end
        end
      end
      ENC_WAIT: begin
        if (first_q) begin
          // This cycle is the final enc_d_clk. Next cycle carries enc_v,
          // and the wait counter reads 0 in that same cycle.
          first_d    = 1'b0;
          enc_v_d    = 1'b1;
          wait_cnt_d = '0;
        end else if (enc_vout) begin
          // This also covers a result arriving in the enc_v cycle itself.
          dec_coef_d   = enc_coef;
          dec_voiced_d = enc_voiced;
          dec_v_d      = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = COLLECT;
        end else if (wait_cnt_q == LAST_WAIT) begin
          err_d   = 1'b1;
          state_d = COLLECT;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      smp_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      first_q      <= 1'b0;
      enc_x_q      <= '0;
      enc_d_clk_q  <= 1'b0;
      enc_v_q      <= 1'b0;
      dec_v_q      <= 1'b0;
      dec_voiced_q <= 1'b0;
      dec_coef_q   <= '0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      smp_cnt_q    <= smp_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      first_q      <= first_d;
      enc_x_q      <= enc_x_d;
      enc_d_clk_q  <= enc_d_clk_d;
      enc_v_q      <= enc_v_d;
      dec_v_q      <= dec_v_d;
      dec_voiced_q <= dec_voiced_d;
      dec_coef_q   <= dec_coef_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

  assign s_ready       = (state_q == COLLECT);
  assign enc_x         = enc_x_q;
  assign enc_d_clk     = enc_d_clk_q;
  assign enc_v         = enc_v_q;
  assign dec_v         = dec_v_q;
  assign dec_voiced    = dec_voiced_q;
  assign dec_coef      = dec_coef_q;
  assign dec_pulserate = 16'(PULSE_RATE);
  assign dec_lpcrate   = 16'(LPC_RATE);
  assign frame_cnt     = frame_cnt_q;
  assign err_timeout   = err_q;
  assign dbg_enc_wait  = (state_q == ENC_WAIT);

endmodule

// File: tb/tb_lpc_frame_sched.sv
// Bench for lpc_frame_sched with FRAME_LEN=4 and TIMEOUT=8. A cycle-stamped
// behavioural model predicts every output. A negedge compare process checks
// the DUT against that model. Directed sequences add literal expectations.
module tb_lpc_frame_sched;

  localparam int FL = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [15:0]  enc_x;
  logic         enc_d_clk;
  logic         enc_v;
  logic         enc_vout = 1'b0;
  logic         enc_voiced = 1'b0;
  logic [175:0] enc_coef = '0;
  logic         dec_v;
  logic         dec_voiced;
  logic [175:0] dec_coef;
  logic [15:0]  dec_pulserate;
  logic [15:0]  dec_lpcrate;
  logic [15:0]  frame_cnt;
  logic         err_timeout;
  logic         dbg_enc_wait;

  int checks = 0;
  int errors = 0;

  lpc_frame_sched #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .enc_x(enc_x), .enc_d_clk(enc_d_clk), .enc_v(enc_v),
    .enc_vout(enc_vout), .enc_voiced(enc_voiced), .enc_coef(enc_coef),
    .dec_v(dec_v), .dec_voiced(dec_voiced), .dec_coef(dec_coef),
    .dec_pulserate(dec_pulserate), .dec_lpcrate(dec_lpcrate),
    .frame_cnt(frame_cnt), .err_timeout(err_timeout),
    .dbg_enc_wait(dbg_enc_wait)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual %h required %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cyc numbers the cycle that ends at the current rising edge. A completed
  // frame schedules enc_v two cycles after its last accept. A result is
  // taken from that cycle up to TO-1 cycles later; otherwise a timeout fires.
  int           cyc = 0;
  bit           model_live = 0;
  bit           m_collect = 1;
  int           m_cnt = 0;
  int           ev_cyc = -1;
  logic         exp_dclk, exp_v, exp_dec_v, exp_voiced, exp_err;
  logic [15:0]  exp_x, exp_frame;
  logic [175:0] exp_coef;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_collect = 1; m_cnt = 0; ev_cyc = -1;
        exp_x = '0; exp_dclk = 0; exp_v = 0; exp_dec_v = 0;
        exp_voiced = 0; exp_coef = '0; exp_frame = '0; exp_err = 0;
      end else begin
        exp_dclk = 0; exp_v = 0; exp_dec_v = 0;
        if (m_collect) begin
          if (s_valid) begin
            exp_dclk = 1;
            exp_x = s_data;
            m_cnt++;
            if (m_cnt == FL) begin
              m_cnt = 0;
              m_collect = 0;
              ev_cyc = cyc + 2;
            end
          end
        end else begin
          if (cyc + 1 == ev_cyc) exp_v = 1;
          if (cyc >= ev_cyc && enc_vout) begin
            exp_dec_v = 1;
            exp_coef = enc_coef;
            exp_voiced = enc_voiced;
            exp_frame = exp_frame + 16'd1;
            m_collect = 1;
          end else if (cyc == ev_cyc + TO - 1) begin
            exp_err = 1;
            m_collect = 1;
          end
        end
      end
      model_live = 1;
      cyc++;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("s_ready", s_ready, m_collect);
        chk("enc_d_clk", enc_d_clk, exp_dclk);
        chk("enc_x", enc_x, exp_x);
        chk("enc_v", enc_v, exp_v);
        chk("dec_v", dec_v, exp_dec_v);
        chk("dec_voiced", dec_voiced, exp_voiced);
        chk("dec_coef", dec_coef, exp_coef);
        chk("frame_cnt", frame_cnt, exp_frame);
        chk("err_timeout", err_timeout, exp_err);
        chk("dec_pulserate", dec_pulserate, 16'd80);
        chk("dec_lpcrate", dec_lpcrate, 16'd240);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sends one frame. base+i is the data of sample i. gap idle cycles follow
  // every sample except the last.
  task automatic send_frame(input logic [15:0] base, input int gap);
    for (int i = 0; i < FL; i++) begin
      s_data = base + 16'(i);
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      if (i < FL - 1) repeat (gap) tick();
    end
  endtask

  // Returns positioned in the enc_v cycle. An expired bound counts as a failure.
  task automatic wait_enc_v();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (enc_v) seen = 1;
      else tick();
    end
    chk("enc_v_seen", seen, 1'b1);
  endtask

  task automatic deliver(input int d, input logic [175:0] coef, input logic v);
    repeat (d) tick();
    enc_coef = coef;
    enc_voiced = v;
    enc_vout = 1'b1;
    tick();
    enc_vout = 1'b0;
  endtask

  function automatic logic [175:0] rand_coef();
    logic [175:0] c;
    for (int k = 0; k < 11; k++) c[16*k +: 16] = 16'($urandom_range(0, 65535));
    return c;
  endfunction

  // ---------------- directed sequences ----------------
  logic [175:0] pat;
  logic [175:0] rc;

  initial begin
    for (int k = 0; k < 11; k++) pat[16*k +: 16] = 16'h1000 + 16'(k);

    repeat (3) tick();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_dec_coef", dec_coef, '0);
    reset = 1'b0;
    tick();

    // Timeout: no encoder answer.
    send_frame(16'd5, 0);
    chk("to_s_ready_low", s_ready, 1'b0);
    chk("to_last_x", enc_x, 16'd8);
    wait_enc_v();
    repeat (7) tick();
    chk("to_err_before", err_timeout, 1'b0);
    tick();
    chk("to_err_at_8", err_timeout, 1'b1);
    chk("to_frame_cnt", frame_cnt, 16'd0);
    chk("to_s_ready", s_ready, 1'b1);
    tick();

    // Normal frame: samples 1..4, encoder answers 3 cycles after enc_v.
    send_frame(16'd1, 0);
    chk("n_last_x", enc_x, 16'd4);
    chk("n_s_ready_low", s_ready, 1'b0);
    wait_enc_v();
    deliver(3, pat, 1'b1);
    chk("n_dec_v", dec_v, 1'b1);
    chk("n_dec_coef", dec_coef, pat);
    chk("n_dec_a10", dec_coef[175:160], 16'h100A);
    chk("n_frame_cnt", frame_cnt, 16'd1);
    chk("n_s_ready", s_ready, 1'b1);
    chk("n_err_sticky", err_timeout, 1'b1);
    tick();

    // Gapped input with a stray encoder result mid-frame.
    for (int i = 0; i < FL; i++) begin
      s_data = 16'hF000 + 16'(i);
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      if (i == 1) begin
        enc_coef = rand_coef();
        enc_voiced = 1'b0;
        enc_vout = 1'b1;
      end
      if (i < FL - 1) begin
        tick();
        enc_vout = 1'b0;
        tick(); tick();
      end
    end
    chk("g_stray_frame_cnt", frame_cnt, 16'd1);
    chk("g_stray_coef", dec_coef, pat);
    wait_enc_v();
    deliver(0, rand_coef(), 1'b0);
    chk("g_same_cycle_dec_v", dec_v, 1'b1);
    chk("g_frame_cnt", frame_cnt, 16'd2);
    chk("g_voiced", dec_voiced, 1'b0);
    tick();

    // A few frames with varied data and answer latency.
    for (int f = 0; f < 3; f++) begin
      send_frame(16'($urandom_range(0, 65535)), $urandom_range(0, 2));
      wait_enc_v();
      deliver($urandom_range(0, 7), rand_coef(), 1'($urandom_range(0, 1)));
      tick();
    end
    chk("r_frame_cnt", frame_cnt, 16'd5);

    // Reset while waiting for the encoder, then a late result.
    send_frame(16'd100, 0);
    wait_enc_v();
    tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    deliver(0, pat, 1'b1);
    tick();
    chk("r_dec_v", dec_v, 1'b0);
    chk("r_frame_cnt0", frame_cnt, 16'd0);
    chk("r_dec_coef0", dec_coef, '0);
    chk("r_voiced0", dec_voiced, 1'b0);
    chk("r_err0", err_timeout, 1'b0);
    chk("r_s_ready", s_ready, 1'b1);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    exp_frame = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("w_preset", frame_cnt, 16'hFFFF);
    send_frame(16'd7, 1);
    wait_enc_v();
    rc = rand_coef();
    deliver(2, rc, 1'b1);
    chk("w_dec_v", dec_v, 1'b1);
    chk("w_wrap", frame_cnt, 16'd0);
    chk("w_coef", dec_coef, rc);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual running required finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
